// File: rtl/cache_pkg.sv
// Shared FSM state type and width/address helpers for the set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_RESPOND
    } state_t;

    function automatic int unsigned off_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                          input int unsigned line_bytes);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

    // Line-aligned byte address {tag, idx, 0}; caller narrows to its address width.
    function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                              input int unsigned idx_bits, input int unsigned off_bits);
        return (tag << (idx_bits + off_bits)) | (idx << off_bits);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim selection for one set; ages stay a permutation of 0..WAYS-1.
module cache_lru
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned AGE_W = 2
) (
    input  logic [WAYS-1:0][AGE_W-1:0] i_age,
    input  logic [WAYS-1:0]            i_acc_oh,
    input  logic                       i_upd_en,
    output logic [WAYS-1:0][AGE_W-1:0] o_age_nxt,
    output logic [AGE_W-1:0]           o_victim
);

    logic [AGE_W-1:0] w_acc_age;

    always_comb begin
        w_acc_age = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (i_acc_oh[w]) w_acc_age = w_acc_age | i_age[w];
        end
    end

    // Accessed way becomes youngest; only ways younger than it age by one.
    always_comb begin
        o_age_nxt = i_age;
        if (i_upd_en) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (i_acc_oh[w])
                    o_age_nxt[w] = '0;
                else if (i_age[w] < w_acc_age)
                    o_age_nxt[w] = i_age[w] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        o_victim = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (i_age[w] == AGE_W'(WAYS - 1)) o_victim = AGE_W'(w);
        end
    end

endmodule

// File: rtl/sa_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller, blocking one request at a time.
// Define CACHE_STATS_EN to add the stat_hits/stat_misses request counters.
module sa_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 256,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic                      cpu_req_we,
    input  logic [ADDR_W-1:0]         cpu_req_addr,
    input  logic [DATA_W-1:0]         cpu_req_wdata,
    input  logic [DATA_W/8-1:0]       cpu_req_be,
    output logic                      cpu_rsp_valid,
    output logic [DATA_W-1:0]         cpu_rsp_rdata,
    output logic                      cpu_rsp_hit,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [LINE_BYTES*8-1:0]   mem_req_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [LINE_BYTES*8-1:0]   mem_rsp_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]               stat_hits,
    output logic [31:0]               stat_misses
`endif
);

    localparam int unsigned OFF_W  = off_w(LINE_BYTES);
    localparam int unsigned IDX_W  = idx_w(SETS);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned AGE_W  = $clog2(WAYS);
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned BE_LG  = $clog2(BE_W);
    localparam int unsigned WORD_W = (OFF_W > BE_LG) ? OFF_W - BE_LG : 1;
    localparam int unsigned LIDX_W = $clog2(LINE_W);

    logic [TAG_W-1:0]            r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]           r_data  [WAYS][SETS];
    logic [WAYS-1:0]             r_valid [SETS];
    logic [WAYS-1:0]             r_dirty [SETS];
    logic [WAYS-1:0][AGE_W-1:0]  r_age   [SETS];

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we, r_first_miss;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [BE_W-1:0]     r_be;
    logic [AGE_W-1:0]    r_victim;
    logic                r_req_ready, r_rsp_valid, r_rsp_hit;
    logic                r_mem_valid, r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;

    logic [IDX_W-1:0]            w_idx;
    logic [TAG_W-1:0]            w_tag;
    logic [WORD_W-1:0]           w_word;
    logic [LIDX_W-1:0]           w_wbase;
    logic [WAYS-1:0]             w_hit;
    logic                        w_hit_any;
    logic [AGE_W-1:0]            w_hit_way, w_victim, w_lru_victim;
    logic [LINE_W-1:0]           w_hit_line, w_merged;
    logic [DATA_W-1:0]           w_hit_word;
    logic [WAYS-1:0][AGE_W-1:0]  w_age_nxt;
    logic                        w_lru_upd, w_store_hit, w_refill, w_accept;

    assign w_idx      = r_addr[OFF_W +: IDX_W];
    assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word     = WORD_W'(r_addr[OFF_W-1:0] >> BE_LG);
    assign w_wbase    = LIDX_W'(w_word) * LIDX_W'(DATA_W);
    assign w_hit_line = r_data[w_hit_way][w_idx];
    assign w_hit_word = w_hit_line[w_wbase +: DATA_W];
    assign w_hit_any  = |w_hit;

    always_comb begin
        w_hit     = '0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_hit[w] = r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag);
            if (w_hit[w]) w_hit_way = AGE_W'(w);
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way.
    always_comb begin
        w_victim = w_lru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = AGE_W'(w);
        end
    end

    always_comb begin
        w_merged = w_hit_line;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (r_be[b]) w_merged[w_wbase + LIDX_W'(b * 8) +: 8] = r_wdata[b*8 +: 8];
        end
    end

    cache_lru #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
        .i_age     (r_age[w_idx]),
        .i_acc_oh  (w_hit),
        .i_upd_en  (w_lru_upd),
        .o_age_nxt (w_age_nxt),
        .o_victim  (w_lru_victim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_lru_upd   = 1'b0;
        w_store_hit = 1'b0;
        w_refill    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = cpu_req_valid && r_req_ready;
                if (w_accept) w_state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                w_lru_upd   = w_hit_any;
                w_store_hit = w_hit_any && r_we;
                if (w_hit_any)
                    w_state_nxt = ST_RESPOND;
                else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                    w_state_nxt = ST_WRITEBACK;
                else
                    w_state_nxt = ST_REFILL_REQ;
            end
            ST_WRITEBACK:   if (mem_req_ready) w_state_nxt = ST_REFILL_REQ;
            ST_REFILL_REQ:  if (mem_req_ready) w_state_nxt = ST_REFILL_WAIT;
            ST_REFILL_WAIT: begin
                w_refill = mem_rsp_valid;
                if (mem_rsp_valid) w_state_nxt = ST_LOOKUP;
            end
            ST_RESPOND:     w_state_nxt = ST_IDLE;
            default:        w_state_nxt = ST_IDLE;
        endcase
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_store_hit) begin
            r_data[w_hit_way][w_idx] <= w_merged;
        end else if (w_refill) begin
            r_data[r_victim][w_idx] <= mem_rsp_rdata;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) r_age[s][w] <= AGE_W'(w);
            end
        end else begin
            if (w_lru_upd)   r_age[w_idx] <= w_age_nxt;
            if (w_store_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
            if (w_refill) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
        end
    end

    // Request capture and registered outputs, loaded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_first_miss <= 1'b0;
            r_victim     <= '0;
            r_rdata      <= '0;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (w_accept) begin
                r_addr       <= cpu_req_addr;
                r_we         <= cpu_req_we;
                r_wdata      <= cpu_req_wdata;
                r_be         <= cpu_req_be;
                r_first_miss <= 1'b0;
            end
            if (r_state == ST_LOOKUP) begin
                if (w_hit_any) begin
                    r_rdata <= r_we ? '0 : w_hit_word;
                end else begin
                    r_first_miss <= 1'b1;
                    r_victim     <= w_victim;
                end
            end
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESPOND);
            r_rsp_hit   <= (w_state_nxt == ST_RESPOND) && !r_first_miss;
            r_mem_valid <= (w_state_nxt == ST_WRITEBACK) || (w_state_nxt == ST_REFILL_REQ);
            if (r_state == ST_LOOKUP && w_state_nxt == ST_WRITEBACK) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= ADDR_W'(line_addr(64'(r_tag[w_victim][w_idx]), 64'(w_idx), IDX_W, OFF_W));
                r_mem_wdata <= r_data[w_victim][w_idx];
            end else if (w_state_nxt == ST_REFILL_REQ && r_state != ST_REFILL_REQ) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= ADDR_W'(line_addr(64'(w_tag), 64'(w_idx), IDX_W, OFF_W));
            end
        end
    end

    assign cpu_req_ready = r_req_ready;
    assign cpu_rsp_valid = r_rsp_valid;
    assign cpu_rsp_rdata = r_rdata;
    assign cpu_rsp_hit   = r_rsp_hit;
    assign mem_req_valid = r_mem_valid;
    assign mem_req_we    = r_mem_we;
    assign mem_req_addr  = r_mem_addr;
    assign mem_req_wdata = r_mem_wdata;

`ifdef CACHE_STATS_EN
    logic [31:0] r_stat_hits, r_stat_misses;

    // One count per request, classified by the first-lookup hit flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (r_state == ST_RESPOND) begin
            if (r_rsp_hit) r_stat_hits   <= r_stat_hits + 32'd1;
            else           r_stat_misses <= r_stat_misses + 32'd1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed self-checking bench for sa_cache_ctrl with a small line-memory responder.
module tb_sa_cache_ctrl;

    localparam int unsigned LINE_W = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0]       cpu_req_addr, cpu_req_wdata;
    logic [3:0]        cpu_req_be;
    logic              cpu_rsp_valid, cpu_rsp_hit;
    logic [31:0]       cpu_rsp_rdata;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]       mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]       stat_hits, stat_misses;
`endif

    sa_cache_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_req_be    (cpu_req_be),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .cpu_rsp_hit   (cpu_rsp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int stall_cycles = 0;
    bit bp_ok = 1'b1;

    logic [LINE_W-1:0] tb_mem [logic [31:0]];
    logic              log_we    [$];
    logic [31:0]       log_addr  [$];
    logic [LINE_W-1:0] log_wdata [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Unwritten lines read back with each word equal to its own byte address.
    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        if (tb_mem.exists(a)) return tb_mem[a];
        for (int j = 0; j < 16; j++) l[j*32 +: 32] = a + 32'(4 * j);
        return l;
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic hit, output int cyc);
        logic rq_v, rq_we, rdy_q, st_seen, done;
        logic [31:0] rq_a, st_a, rsp_a;
        logic [LINE_W-1:0] rq_wd, st_wd;
        int rsp_cnt, stall;
        stall = stall_cycles; rsp_cnt = -1; rdy_q = 0; rq_v = 0; rq_we = 0; st_seen = 0;
        done = 0; rd = '0; hit = 0; cyc = -1; rq_a = '0; rq_wd = '0; st_a = '0; st_wd = '0; rsp_a = '0;
        for (int i = 0; i < 50 && !cpu_req_ready; i++) @(negedge clk);
        check("req_ready", 64'(cpu_req_ready), 64'd1);
        cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wd; cpu_req_be = be;
        @(negedge clk);
        cpu_req_valid = 0;
        for (int c = 1; c <= 300 && !done; c++) begin
            mem_rsp_valid = 0;
            if (rdy_q && rq_v) begin
                log_we.push_back(rq_we); log_addr.push_back(rq_a); log_wdata.push_back(rq_wd);
                if (rq_we) tb_mem[rq_a] = rq_wd;
                else begin rsp_cnt = 2; rsp_a = rq_a; end
            end
            if (cpu_rsp_valid) begin
                rd = cpu_rsp_rdata; hit = cpu_rsp_hit; cyc = c; done = 1;
                mem_req_ready = 0;
            end else begin
                if (rsp_cnt == 0) begin
                    mem_rsp_valid = 1; mem_rsp_rdata = mem_line(rsp_a); rsp_cnt = -1;
                end else if (rsp_cnt > 0) rsp_cnt--;
                rq_v = mem_req_valid; rq_we = mem_req_we; rq_a = mem_req_addr; rq_wd = mem_req_wdata;
                if (stall > 0 && (mem_req_valid || st_seen)) begin
                    if (!mem_req_valid || cpu_req_ready) bp_ok = 0;
                    if (!st_seen) begin st_a = mem_req_addr; st_wd = mem_req_wdata; st_seen = 1; end
                    else if (mem_req_addr !== st_a || mem_req_wdata !== st_wd) bp_ok = 0;
                    stall--;
                    mem_req_ready = 0;
                end else mem_req_ready = mem_req_valid;
                rdy_q = mem_req_ready;
                @(negedge clk);
            end
        end
        mem_rsp_valid = 0; mem_req_ready = 0;
        check("rsp_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("rsp_pulse", 64'(cpu_rsp_valid), 64'd0);
    endtask

    logic [31:0]       rd;
    logic              hit;
    int                cyc, n0;
    logic [LINE_W-1:0] ln;

    initial begin
        rst = 1; cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        cpu_req_be = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
        ln = '0; ln[63:32] = 32'hDEAD_BEEF; tb_mem[32'h0000_1000] = ln;
        ln = '0; ln[31:0]  = 32'h1122_3344; tb_mem[32'h0000_2000] = ln;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(cpu_req_ready), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
        check("rst_rdata", 64'(cpu_rsp_rdata), 64'd0);
        rst = 0;
        @(negedge clk);
        check("idle_ready", 64'(cpu_req_ready), 64'd1);

        // clean read miss, then the same load hits
        n0 = log_we.size();
        txn(0, 32'h0000_1004, '0, '0, rd, hit, cyc);
        check("rm_rdata", 64'(rd), 64'hDEAD_BEEF);
        check("rm_hit", 64'(hit), 64'd0);
        check("rm_nreq", 64'(log_we.size() - n0), 64'd1);
        check("rm_we", 64'(log_we[n0]), 64'd0);
        check("rm_addr", 64'(log_addr[n0]), 64'h1000);
        n0 = log_we.size();
        txn(0, 32'h0000_1004, '0, '0, rd, hit, cyc);
        check("rh_rdata", 64'(rd), 64'hDEAD_BEEF);
        check("rh_hit", 64'(hit), 64'd1);
        check("rh_cyc", 64'(cyc), 64'd2);
        check("rh_nreq", 64'(log_we.size() - n0), 64'd0);

        // byte-enable store merge
        txn(0, 32'h0000_2000, '0, '0, rd, hit, cyc);
        check("be_fill", 64'(rd), 64'h1122_3344);
        txn(1, 32'h0000_2000, 32'hAABB_CCDD, 4'b0011, rd, hit, cyc);
        check("be_st_hit", 64'(hit), 64'd1);
        check("be_st_rdata", 64'(rd), 64'd0);
        txn(0, 32'h0000_2000, '0, '0, rd, hit, cyc);
        check("be_ld", 64'(rd), 64'h1122_CCDD);
        check("be_ld_hit", 64'(hit), 64'd1);

        // fill set 5 with dirty lines, age tags 1..3, then evict tag 0
        for (int t = 0; t < 4; t++)
            txn(1, 32'(t * 32'h4000 + 32'h140), 32'h5000_0000 + 32'(t), 4'hF, rd, hit, cyc);
        for (int t = 1; t < 4; t++) begin
            txn(0, 32'(t * 32'h4000 + 32'h140), '0, '0, rd, hit, cyc);
            check("lru_touch_hit", 64'(hit), 64'd1);
        end
        n0 = log_we.size();
        txn(0, 32'h0001_0140, '0, '0, rd, hit, cyc);
        check("ev_rdata", 64'(rd), 64'h0001_0140);
        check("ev_hit", 64'(hit), 64'd0);
        check("ev_nreq", 64'(log_we.size() - n0), 64'd2);
        check("ev_wb_we", 64'(log_we[n0]), 64'd1);
        check("ev_wb_addr", 64'(log_addr[n0]), 64'h140);
        check("ev_wb_w0", 64'(log_wdata[n0][31:0]), 64'h5000_0000);
        check("ev_wb_w1", 64'(log_wdata[n0][63:32]), 64'h144);
        check("ev_rf_we", 64'(log_we[n0+1]), 64'd0);
        check("ev_rf_addr", 64'(log_addr[n0+1]), 64'h0001_0140);
        n0 = log_we.size();
        txn(0, 32'h0000_0140, '0, '0, rd, hit, cyc);
        check("ev2_rdata", 64'(rd), 64'h5000_0000);
        check("ev2_wb_addr", 64'(log_addr[n0]), 64'h4140);
        check("ev2_wb_w0", 64'(log_wdata[n0][31:0]), 64'h5000_0001);

        // memory back-pressure on a clean refill
        stall_cycles = 10; bp_ok = 1;
        txn(0, 32'h0000_3000, '0, '0, rd, hit, cyc);
        stall_cycles = 0;
        check("bp_stable", 64'(bp_ok), 64'd1);
        check("bp_rdata", 64'(rd), 64'h3000);
        check("bp_hit", 64'(hit), 64'd0);

        // reset while a refill request is outstanding drops it at once
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h0000_7080;
        @(negedge clk); cpu_req_valid = 0;
        for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clk);
        check("rq_pending", 64'(mem_req_valid), 64'd1);
        rst = 1; #1;
        check("rst_drop_mvalid", 64'(mem_req_valid), 64'd0);
        check("rst_drop_ready", 64'(cpu_req_ready), 64'd0);
        @(negedge clk); rst = 0; @(negedge clk);
        check("rst_drop_idle", 64'(cpu_req_ready), 64'd1);

        // reset during REFILL_WAIT, late memory response ignored
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h0000_6040;
        @(negedge clk); cpu_req_valid = 0;
        for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clk);
        check("rw_req_addr", 64'(mem_req_addr), 64'h6040);
        mem_req_ready = 1; @(negedge clk); mem_req_ready = 0; @(negedge clk);
        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        check("rw_mvalid", 64'(mem_req_valid), 64'd0);
        check("rw_ready", 64'(cpu_req_ready), 64'd1);
        mem_rsp_valid = 1; mem_rsp_rdata = {LINE_W{1'b1}};
        @(negedge clk); mem_rsp_valid = 0; @(negedge clk);
        check("late_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
        check("late_ready", 64'(cpu_req_ready), 64'd1);
        txn(0, 32'h0000_6040, '0, '0, rd, hit, cyc);
        check("rw_remiss", 64'(hit), 64'd0);
        check("rw_rdata", 64'(rd), 64'h6040);

        // three hits then a second miss since the last reset
        for (int k = 0; k < 3; k++) begin
            txn(0, 32'h0000_6040, '0, '0, rd, hit, cyc);
            check("st_hit", 64'(hit), 64'd1);
        end
        txn(0, 32'h0000_6080, '0, '0, rd, hit, cyc);
        check("st_miss", 64'(hit), 64'd0);
`ifdef CACHE_STATS_EN
        check("stat_hits", 64'(stat_hits), 64'd3);
        check("stat_misses", 64'(stat_misses), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa_cache_ctrl.md
Name: sa_cache_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller. It sits between a single-issue CPU load/store port and a line-wide memory port. Each request is handled as a blocking transaction with a valid/ready handshake. Replacement is true LRU using per-set age counters; dirty victims are written back before the refill.

Parameters:
WAYS, 4, associativity; power of 2, >=2
SETS, 256, sets per way; power of 2
LINE_BYTES, 64, bytes per line; power of 2, >= DATA_W/8
ADDR_W, 32, byte-address width
DATA_W, 32, CPU word width; multiple of 8
Derived (localparam):
- OFF_W = clog2(LINE_BYTES)
- IDX_W = clog2(SETS)
- TAG_W = ADDR_W-IDX_W-OFF_W
- LINE_W = LINE_BYTES*8
- AGE_W = clog2(WAYS)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_req_valid  in  1  request present
cpu_req_ready  out  1  controller can accept
cpu_req_we  in  1  1=store, 0=load
cpu_req_addr  in  ADDR_W  byte address; word-aligned
cpu_req_wdata  in  DATA_W  store data
cpu_req_be  in  DATA_W/8  store byte enables
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rsp_rdata  out  DATA_W  load data; 0 for stores
cpu_rsp_hit  out  1  first lookup of this request hit
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=writeback, 0=refill read
mem_req_addr  out  ADDR_W  line-aligned address (offset bits 0)
mem_req_wdata  out  LINE_W  victim line
mem_rsp_valid  in  1  refill data valid
mem_rsp_rdata  in  LINE_W  refill line

Behaviour:
- Reset: all valid and dirty bits cleared; age[s][w]=w for every set; FSM=IDLE; all outputs 0. Tag/data arrays are not reset.
- Reset mid-operation: the in-flight request is dropped, mem_req_valid drops immediately, and dirty data is lost.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE:
  - cpu_req_ready=1 only in IDLE.
  - valid&ready latches addr/we/wdata/be, clears first_miss, moves to LOOKUP.
- LOOKUP:
  - hit[w] = valid[idx][w] & (tag[idx][w]==req_tag); at most one way may hit.
  - Hit on load: capture the word at offset into rdata.
  - Hit on store: merge wdata into the line by be; set dirty.
  - Either hit: update LRU, go to RESPOND.
  - Miss: set first_miss. Victim = lowest-index invalid way, else the way with age==WAYS-1.
  - Miss with victim valid&dirty goes to WRITEBACK; otherwise to REFILL_REQ.
- WRITEBACK: mem_req_valid=1, we=1, addr={victim_tag,idx,0}, wdata=victim line. On mem_req_ready, go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, we=0, addr={req_tag,idx,0}. On mem_req_ready, go to REFILL_WAIT.
- Memory request rules: valid/addr/wdata are held stable until ready. Valid never drops without ready.
- REFILL_WAIT:
  - On mem_rsp_valid: write the line and tag into the victim way, valid=1, dirty=0, return to LOOKUP. The replay hits.
  - mem_rsp_valid outside REFILL_WAIT is ignored.
- RESPOND: cpu_rsp_valid=1 for exactly one cycle, cpu_rsp_hit=~first_miss, then IDLE. There is no response back-pressure.
- Latency:
  - Hit: accept at edge 0, rsp_valid during cycle 2.
  - Clean miss: 4 cycles + memory wait.
  - Dirty miss: +1 cycle + writeback wait.
- LRU update on access of way a with old age k: age[a]=0; every way with age<k gets +1; the others are unchanged. The ages in a set stay a permutation of 0..WAYS-1.
- An access to a way already at age 0 leaves the set's ages unchanged.

Optional Feature:
CACHE_STATS_EN:
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0], both reset to 0.
  - One increment per request, at RESPOND, by hit flag.
  - The counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the state enum
  - the width-derivation functions (OFF_W/IDX_W/TAG_W from the parameters)
  - the line-address construction function
- Sub-module cache_lru:
  - Inputs: current set age vector, accessed-way one-hot, update enable.
  - Outputs: next age vector and the victim index (combinational).
  - The controller holds the per-set age storage.

Test Plan:
- Read miss, clean, empty cache: load 0x0000_1004, memory returns a line with word1=0xDEAD_BEEF.
  - mem_req we=0, addr=0x0000_1000.
  - Response rdata=0xDEAD_BEEF, hit=0.
  - A repeat load responds 2 cycles after accept with hit=1 and no memory request.
- Byte-enable store hit: line word0=0x1122_3344, store wdata=0xAABB_CCDD, be=4'b0011.
  - Following load reads 0x1122_CCDD; dirty set.
- Dirty LRU eviction, WAYS=4: dirty stores to tags 0..3 of set 5, loads to tags 1,2,3, then load tag 4.
  - Writeback of tag 0's line is issued first, then the refill, with mem_req_we 1 then 0.
- Memory back-pressure: hold mem_req_ready=0 for 10 cycles.
  - mem_req_valid/addr/wdata stay stable; cpu_req_ready stays 0.
  - Response follows after ready.
- Reset during REFILL_WAIT: rst pulse.
  - mem_req_valid=0 and cpu_req_ready=1 after release.
  - A late mem_rsp_valid is ignored.
  - A load of the same address misses again.
- With CACHE_STATS_EN: 3 hits + 2 misses gives stat_hits=3, stat_misses=2.
